// File: rtl/multicycle_compute_unit.sv
// RV32IM-style execute stage: 1-cycle ALU ops, XLEN+1-cycle iterative MUL/DIV; one result held.
// Backpressure: result parks in DONE until out_ready; in_ready only when idle or draining.
module multicycle_compute_unit #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_imm,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_val,
    output logic [4:0]      out_rd,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q;
    logic [XLEN-1:0] out_val_q, hi_q, lo_q, opnd_q;
    logic [4:0]      out_rd_q;
    logic            out_valid_q, busy_q, neg_q;
    logic [2:0]      f3_q;
    logic [SHW-1:0]  cnt_q;

    logic [XLEN-1:0] op_b, alu_res, a_mag, b_mag, hi_d, lo_d, fin_res, div_sel;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic            accept, is_m, is_div, div_zero, div_ovf, fast, md_go, a_neg, b_neg;
    logic signed [XLEN-1:0] sra_res;

    assign in_ready  = !reset && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign out_rd    = out_rd_q;
    assign busy      = busy_q;

    assign op_b     = in_is_imm ? in_imm : in_rs2_val;
    assign shamt    = op_b[SHW-1:0];
    assign is_m     = !in_is_imm && in_funct7 == 7'b0000001;
    assign is_div   = in_funct3[2];
    assign div_zero = op_b == '0;
    assign div_ovf  = !in_funct3[0] && in_rs1_val == MIN_INT && op_b == '1;
    // Divide-by-zero and signed overflow bypass the iterative divider.
    assign fast     = MULDIV_EN && is_m && is_div && (div_zero || div_ovf);
    assign md_go    = MULDIV_EN && is_m && !fast;

    always_comb begin
        alu_res = '0;
        sra_res = $signed(in_rs1_val) >>> shamt;
        if (is_m) begin
            if (fast) begin
                if (div_zero) alu_res = in_funct3[1] ? in_rs1_val : '1;
                else          alu_res = in_funct3[1] ? '0 : MIN_INT;
            end
        end else if (in_is_imm || in_funct7 == 7'b0000000 || in_funct7 == 7'b0100000) begin
            case (in_funct3)
                3'b000: alu_res = (!in_is_imm && in_funct7[5]) ? in_rs1_val - op_b
                                                                : in_rs1_val + op_b;
                3'b001: alu_res = in_rs1_val << shamt;
                3'b010: alu_res[0] = $signed(in_rs1_val) < $signed(op_b);
                3'b011: alu_res[0] = in_rs1_val < op_b;
                3'b100: alu_res = in_rs1_val ^ op_b;
                3'b101: begin
                    if (in_funct7[5]) alu_res = sra_res;
                    else              alu_res = in_rs1_val >> shamt;
                end
                3'b110: alu_res = in_rs1_val | op_b;
                default: alu_res = in_rs1_val & op_b;
            endcase
        end
    end

    // Operands are iterated as magnitudes; the result sign is applied on the final cycle.
    always_comb begin
        if (is_div) begin
            a_neg = in_rs1_val[XLEN-1] && !in_funct3[0];
            b_neg = op_b[XLEN-1] && !in_funct3[0];
        end else begin
            a_neg = in_rs1_val[XLEN-1] && in_funct3 != 3'b011;
            b_neg = op_b[XLEN-1] && (in_funct3 == 3'b000 || in_funct3 == 3'b001);
        end
        a_mag = a_neg ? -in_rs1_val : in_rs1_val;
        b_mag = b_neg ? -op_b : op_b;
    end

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
        if (state_q == S_DIV) begin
            if (!div_trial[XLEN]) begin
                hi_d = div_trial[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        div_sel  = f3_q[1] ? hi_d : lo_d;
        if (state_q == S_DIV)   fin_res = neg_q ? -div_sel : div_sel;
        else if (f3_q == 3'b000) fin_res = prod_fix[XLEN-1:0];
        else                     fin_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_val_q   <= '0;
            out_rd_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            f3_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_MUL, S_DIV: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(XLEN-1)) begin
                        out_val_q   <= fin_res;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        out_rd_q <= in_rd;
                        if (md_go) begin
                            hi_q        <= '0;
                            lo_q        <= a_mag;
                            opnd_q      <= b_mag;
                            neg_q       <= (is_div && in_funct3[1]) ? a_neg : (a_neg ^ b_neg);
                            f3_q        <= in_funct3;
                            cnt_q       <= '0;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= is_div ? S_DIV : S_MUL;
                        end else begin
                            out_val_q   <= alu_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if (state_q == S_DONE && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_compute_unit.sv
// Bench for multicycle_compute_unit: directed corner cases plus random ops vs an arithmetic model.
module tb_multicycle_compute_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_is_imm = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid, out_ready = 1'b1, busy;
    logic [31:0] out_val;
    logic [4:0]  out_rd;

    int n_chk = 0;
    int n_fail = 0;

    multicycle_compute_unit #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_rd(out_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input bit imm, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic signed [31:0] t;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r = '0;
        if (!imm && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                default: begin
                    if (b == 0)                   r = f3[1] ? a : 32'hFFFF_FFFF;
                    else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                                                  r = f3[1] ? 32'h0 : 32'h8000_0000;
                    else if (!f3[0]) begin p = f3[1] ? sa % sb : sa / sb; r = p[31:0]; end
                    else begin p = f3[1] ? ua % ub : ua / ub; r = p[31:0]; end
                end
            endcase
        end else if (imm || f7 == 7'h00 || f7 == 7'h20) begin
            case (f3)
                3'd0: r = (!imm && f7[5]) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = {31'b0, sa < sb};
                3'd3: r = {31'b0, a < b};
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) begin t = $signed(a); t = t >>> b[4:0]; r = t; end
                    else r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_lat(input bit imm, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
        if (imm || f7 != 7'h01) return 1;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic drive(input bit imm, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_is_imm  = imm;
        in_funct3  = f3;
        in_funct7  = f7;
        in_rs1_val = a;
        in_rs2_val = imm ? $urandom : b;
        in_imm     = imm ? b : $urandom;
        in_rd      = rd;
    endtask

    task automatic run_op(input string tag, input bit imm, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_v, input int exp_lat);
        int  lat;
        bit  ok, seen;
        @(negedge clk);
        drive(imm, f3, f7, a, b, rd);
        lat = 0;
        while (!in_ready && lat < 50) begin @(negedge clk); lat++; end
        if (!in_ready) begin
            chk({tag, "_rdy_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        ok = 1'b1;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; lat = i; end
            else if (!busy || in_ready) ok = 1'b0;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (seen) begin
            chk({tag, "_val"}, out_val, exp_v);
            chk({tag, "_rd"}, out_rd, rd);
        end
        if (exp_lat > 1) chk({tag, "_busy"}, ok, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stale;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b;
        logic [11:0] i12;
        bit          imm;

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // ADD then SUB accepted while the ADD result drains
        drive(1'b0, 3'd0, 7'h00, 32'd10, 32'd5, 5'd3);
        @(posedge clk);
        #1 drive(1'b0, 3'd0, 7'h20, 32'd11, 32'd6, 5'd4);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_val", out_val, 15);
        chk("add_rd", out_rd, 3);
        chk("add_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("sub_valid", out_valid, 1);
        chk("sub_val", out_val, 5);
        chk("sub_rd", out_rd, 4);
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        run_op("srai",   1'b1, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0404, 5'd5, 32'hF800_0000, 1);
        run_op("srl",    1'b0, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000, 1);
        run_op("sltu",   1'b0, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF, 5'd7, 32'd1, 1);
        run_op("badf7",  1'b0, 3'd0, 7'h7F, 32'd3, 32'd4, 5'd8, 32'd0, 1);
        run_op("mul",    1'b0, 3'd0, 7'h01, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 33);
        run_op("mulhu",  1'b0, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 1'b0, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        run_op("div",    1'b0, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33);
        run_op("rem",    1'b0, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 33);
        run_op("divu0",  1'b0, 3'd5, 7'h01, 32'd7, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
        run_op("remu0",  1'b0, 3'd7, 7'h01, 32'd7, 32'd0, 5'd15, 32'd7, 1);
        run_op("divovf", 1'b0, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
        run_op("removf", 1'b0, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1);

        // Held result under backpressure
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 7'h00, 32'd20, 32'd22, 5'd9);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_val", out_val, 42);
            chk("bp_rd", out_rd, 9);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);

        // Reset in the middle of a multiply discards it
        drive(1'b0, 3'd0, 7'h01, 32'd123, 32'd456, 5'd20);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_ready_after", in_ready, 1);
        run_op("post_rst_add", 1'b0, 3'd0, 7'h00, 32'd1, 32'd1, 5'd21, 32'd2, 1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0 && out_valid) stale++;
        end
        chk("no_stale_result", stale, 0);

        for (int n = 0; n < 300; n++) begin
            imm = $urandom_range(0, 2) == 0;
            f3  = 3'($urandom_range(0, 7));
            a   = pick();
            case ($urandom_range(0, 5))
                0, 1:    f7 = 7'h01;
                2:       f7 = 7'h20;
                3:       f7 = 7'($urandom);
                default: f7 = 7'h00;
            endcase
            if (imm) begin
                i12 = 12'($urandom);
                if (f3 == 3'd1 || f3 == 3'd5) i12[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                f7 = i12[11:5];
                b  = {{20{i12[11]}}, i12};
            end else begin
                b = pick();
            end
            run_op($sformatf("rnd%0d", n), imm, f3, f7, a, b, 5'($urandom),
                   ref_op(imm, f3, f7, a, b), ref_lat(imm, f3, f7, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=0x0 expected=0x1");
        $fatal(1, "timeout");
    end
endmodule
